umi_arbiter: RTL and testbench

- Request arbiter that produces the one-hot select vector for an N-input UMI one-hot mux. It shares the single outgoing UMI port between N requesters.
- Arbitration is round-robin or fixed-priority. A grant is locked while the output is stalled, so the mux select stays stable until the transaction is accepted.
- Sits directly in front of the mux: grant drives the mux select, and in_ready drives each requester's ready.

---
 rtl/umi_pkg.sv | 11 +
 rtl/umi_arb_priority.sv | 15 +
 rtl/umi_arbiter.sv | 161 ++++++++++++++++
 tb/tb_umi_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/umi_pkg.sv
// Shared definitions for the UMI request arbiter.
// Holds the lock-state encoding used by umi_arbiter.
package umi_pkg;

  // Lock state of the arbiter: free to arbitrate, or holding a stalled grant
  typedef enum logic {
    UMI_ARB_IDLE   = 1'b0,
    UMI_ARB_LOCKED = 1'b1
  } umiArbState_e;

endpackage : umi_pkg

// File: rtl/umi_arb_priority.sv
// Lowest-set-bit one-hot priority encoder.
// Output is all-zero when no request bit is set.
module umi_arb_priority #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant
);

  // Two's-complement trick isolates the least significant set bit
  always_comb begin
    o_grant = i_req & (~i_req + N'(1));
  end

endmodule : umi_arb_priority

// File: rtl/umi_arbiter.sv
// Round-robin / fixed-priority request arbiter that drives the one-hot
// select of an N-input UMI mux. A grant stays locked while the outgoing
// port stalls so the mux select is stable until the transfer is accepted.
// Optional build macro UMI_ARBITER_ONEHOT_CHECK_EN adds a registered
// checker that raises the sticky err_onehot flag; without it err_onehot
// is tied low.
module umi_arbiter
  import umi_pkg::*;
#(
  parameter int N          = 4,
  parameter bit ROUNDROBIN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_valid,
  output logic [N-1:0] in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] grant,
  output logic         err_protocol,
  output logic         err_onehot
);

  umiArbState_e r_state;
  logic [N-1:0] r_mask;
  logic [N-1:0] r_hold;
  logic         r_errProtocol;

  logic [N-1:0] w_masked;
  logic [N-1:0] w_maskedGrant;
  logic [N-1:0] w_rawGrant;
  logic [N-1:0] w_arbGrant;
  logic         w_withdraw;
  logic [N-1:0] w_grant;
  logic         w_outValid;
  logic         w_accept;
  logic         w_stall;
  logic [N-1:0] w_lowerIncl;
  logic [N-1:0] w_maskNext;

  umi_arb_priority #(.N(N)) u_prioMasked (
    .i_req   (w_masked),
    .o_grant (w_maskedGrant)
  );

  umi_arb_priority #(.N(N)) u_prioRaw (
    .i_req   (in_valid),
    .o_grant (w_rawGrant)
  );

  // Pick the grant: held index while locked, otherwise fresh arbitration;
  // a withdrawn lock falls through to re-arbitrate in the same cycle
  always_comb begin
    w_masked   = in_valid & r_mask;
    w_arbGrant = (ROUNDROBIN && (|w_masked)) ? w_maskedGrant : w_rawGrant;
    w_withdraw = (r_state == UMI_ARB_LOCKED) && !(|(in_valid & r_hold));
    if ((r_state == UMI_ARB_LOCKED) && !w_withdraw) begin
      w_grant = r_hold;
    end else begin
      w_grant = w_arbGrant;
    end
    if (reset) begin
      w_grant = '0;
    end
    w_outValid = |w_grant;
    w_accept   = w_outValid & out_ready;
    w_stall    = w_outValid & ~out_ready;
  end

  // Next round-robin mask: only indices above the accepted one keep priority,
  // wrapping to all ones after the top requester is served
  always_comb begin
    w_lowerIncl = w_grant | (w_grant - N'(1));
    if (&w_lowerIncl) begin
      w_maskNext = '1;
    end else begin
      w_maskNext = ~w_lowerIncl;
    end
  end

  // Lock state machine, rotation mask and sticky protocol-error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= UMI_ARB_IDLE;
      r_hold        <= '0;
      r_mask        <= '1;
      r_errProtocol <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mask <= w_maskNext;
      end
      if (w_withdraw) begin
        r_errProtocol <= 1'b1;
      end
      case (r_state)
        UMI_ARB_IDLE: begin
          if (w_stall) begin
            r_hold  <= w_grant;
            r_state <= UMI_ARB_LOCKED;
          end
        end
        UMI_ARB_LOCKED: begin
          if (w_stall) begin
            r_hold  <= w_grant;
          end else begin
            r_state <= UMI_ARB_IDLE;
          end
        end
        default: r_state <= UMI_ARB_IDLE;
      endcase
    end
  end

  assign grant        = w_grant;
  assign out_valid    = w_outValid;
  assign in_ready     = w_grant & {N{out_ready}};
  assign err_protocol = r_errProtocol;

`ifdef UMI_ARBITER_ONEHOT_CHECK_EN
  logic         r_errOnehot;
  logic         r_prevStall;
  logic [N-1:0] r_prevGrant;
  logic         w_multiHot;
  logic         w_unstable;

  // Flag more than one select bit, or a select that moved during a stall
  always_comb begin
    w_multiHot = (w_grant & (w_grant - N'(1))) != '0;
    w_unstable = r_prevStall && (w_grant != r_prevGrant);
  end

  // Remember last cycle's stall/select and latch any violation until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_errOnehot <= 1'b0;
      r_prevStall <= 1'b0;
      r_prevGrant <= '0;
    end else begin
      r_prevStall <= w_stall;
      r_prevGrant <= w_grant;
      if (w_multiHot || w_unstable) begin
        r_errOnehot <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // Report select violations loudly in simulation
  always @(posedge clk) begin
    if (!reset && (w_multiHot || w_unstable)) begin
      $error("umi_arbiter: grant one-hot/stability violation, grant=%b", w_grant);
    end
  end
`endif

  assign err_onehot = r_errOnehot;
`else
  assign err_onehot = 1'b0;
`endif

endmodule : umi_arbiter

// File: tb/tb_umi_arbiter.sv
// Scoreboard bench for umi_arbiter: one round-robin and one fixed-priority
// instance share stimulus; a behavioural model predicts each cycle's
// outputs, a monitor pops and compares them on the falling edge.
module tb_umi_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] inValid;
  logic         outReady;

  logic [N-1:0] rrInReady, fpInReady;
  logic [N-1:0] rrGrant, fpGrant;
  logic         rrOutValid, fpOutValid;
  logic         rrErrProto, fpErrProto;
  logic         rrErrOh, fpErrOh;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0] grant;
    logic         outValid;
    logic [N-1:0] inReady;
    logic         errProto;
    logic         errOh;
  } exp_t;

  typedef struct packed {
    exp_t rr;
    exp_t fp;
  } expPair_t;

  expPair_t sbQueue[$];
  expPair_t popped;

  // Model state, index 0 = round-robin instance, 1 = fixed-priority instance
  int           mPtr[2];
  int           mLock[2];
  int           mGrantIdx[2];
  bit           mWithdraw[2];
  bit           mErr[2];
  bit           mOh[2];
  bit           mPrevStall[2];
  logic [N-1:0] mPrevGrant[2];

  umi_arbiter #(.N(N), .ROUNDROBIN(1'b1)) dutRr (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (inValid),
    .in_ready     (rrInReady),
    .out_valid    (rrOutValid),
    .out_ready    (outReady),
    .grant        (rrGrant),
    .err_protocol (rrErrProto),
    .err_onehot   (rrErrOh)
  );

  umi_arbiter #(.N(N), .ROUNDROBIN(1'b0)) dutFp (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (inValid),
    .in_ready     (fpInReady),
    .out_valid    (fpOutValid),
    .out_ready    (outReady),
    .grant        (fpGrant),
    .err_protocol (fpErrProto),
    .err_onehot   (fpErrOh)
  );

  always #5 clk = ~clk;

  // Round-robin: first valid at or above the pointer, else first valid overall
  function automatic int arbitrate(input bit rr, input int ptr, input logic [N-1:0] v);
    if (rr) begin
      for (int i = ptr; i < N; i++) if (v[i]) return i;
    end
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] idxToVec(input int idx);
    logic [N-1:0] vec;
    vec = '0;
    if (idx >= 0) vec[idx] = 1'b1;
    return vec;
  endfunction

  task automatic resetModel(input int m);
    mPtr[m]       = 0;
    mLock[m]      = -1;
    mGrantIdx[m]  = -1;
    mWithdraw[m]  = 1'b0;
    mErr[m]       = 1'b0;
    mOh[m]        = 1'b0;
    mPrevStall[m] = 1'b0;
    mPrevGrant[m] = '0;
  endtask

  // Clock edge: commit the cycle that just ended into the model state
  task automatic advanceModel();
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        resetModel(m);
      end else begin
        if (mWithdraw[m]) mErr[m] = 1'b1;
`ifdef UMI_ARBITER_ONEHOT_CHECK_EN
        if (mPrevStall[m] && (idxToVec(mGrantIdx[m]) != mPrevGrant[m])) mOh[m] = 1'b1;
`endif
        mPrevStall[m] = (mGrantIdx[m] >= 0) && !outReady;
        mPrevGrant[m] = idxToVec(mGrantIdx[m]);
        if (mGrantIdx[m] >= 0 && outReady) begin
          mPtr[m]  = (mGrantIdx[m] + 1) % N;
          mLock[m] = -1;
        end else if (mGrantIdx[m] >= 0) begin
          mLock[m] = mGrantIdx[m];
        end else begin
          mLock[m] = -1;
        end
      end
    end
  endtask

  // Predict this cycle's outputs from current inputs and model state
  task automatic computeExpect(output expPair_t pair);
    exp_t e[2];
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        resetModel(m);
      end else begin
        mWithdraw[m] = (mLock[m] >= 0) && !inValid[mLock[m]];
        if (mLock[m] >= 0 && !mWithdraw[m]) mGrantIdx[m] = mLock[m];
        else mGrantIdx[m] = arbitrate(m == 0, mPtr[m], inValid);
      end
      e[m].grant    = idxToVec(mGrantIdx[m]);
      e[m].outValid = mGrantIdx[m] >= 0;
      e[m].inReady  = outReady ? idxToVec(mGrantIdx[m]) : '0;
      e[m].errProto = mErr[m];
      e[m].errOh    = mOh[m];
    end
    pair.rr = e[0];
    pair.fp = e[1];
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic rdy, input logic rst);
    expPair_t pair;
    @(posedge clk);
    advanceModel();
    #1;
    inValid  = v;
    outReady = rdy;
    reset    = rst;
    computeExpect(pair);
    sbQueue.push_back(pair);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: compare every pending prediction against the live outputs
  always @(negedge clk) begin
    while (sbQueue.size() > 0) begin
      popped = sbQueue.pop_front();
      checkOutput("rr.grant",    32'(rrGrant),    32'(popped.rr.grant));
      checkOutput("rr.outValid", 32'(rrOutValid), 32'(popped.rr.outValid));
      checkOutput("rr.inReady",  32'(rrInReady),  32'(popped.rr.inReady));
      checkOutput("rr.errProto", 32'(rrErrProto), 32'(popped.rr.errProto));
      checkOutput("rr.errOh",    32'(rrErrOh),    32'(popped.rr.errOh));
      checkOutput("fp.grant",    32'(fpGrant),    32'(popped.fp.grant));
      checkOutput("fp.outValid", 32'(fpOutValid), 32'(popped.fp.outValid));
      checkOutput("fp.inReady",  32'(fpInReady),  32'(popped.fp.inReady));
      checkOutput("fp.errProto", 32'(fpErrProto), 32'(popped.fp.errProto));
      checkOutput("fp.errOh",    32'(fpErrOh),    32'(popped.fp.errOh));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    inValid  = '0;
    outReady = 1'b0;
    for (int m = 0; m < 2; m++) resetModel(m);

    // Reset state, then full rotation with one accept per cycle
    applyStimulus(4'b1111, 1'b1, 1'b1);
    applyStimulus(4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(4'b1111, 1'b1, 1'b0);

    // Stall with 0101, raise requester 1 mid-stall, then accept
    applyStimulus(4'b0101, 1'b0, 1'b1);
    applyStimulus(4'b0101, 1'b0, 1'b0);
    applyStimulus(4'b0111, 1'b0, 1'b0);
    applyStimulus(4'b0111, 1'b0, 1'b0);
    applyStimulus(4'b0111, 1'b1, 1'b0);
    applyStimulus(4'b0101, 1'b1, 1'b0);
    applyStimulus(4'b0101, 1'b1, 1'b0);

    // Fixed priority starves requester 3
    for (int i = 0; i < 4; i++) applyStimulus(4'b1010, 1'b1, 1'b0);

    // Locked requester 2 withdraws during a stall
    applyStimulus(4'b1111, 1'b1, 1'b1);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    applyStimulus(4'b1011, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b1011, 1'b1, 1'b0);

    // Reset asserted while requester 2 is locked, then release
    applyStimulus(4'b1111, 1'b1, 1'b1);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b1);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 99) == 0));
    end

    // Final lock on requester 0 for the checker test
    applyStimulus(4'b1111, 1'b0, 1'b1);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b0);

    for (int i = 0; i < 10 && sbQueue.size() > 0; i++) @(negedge clk);
    checkOutput("scoreboard.drain", 32'(sbQueue.size()), 32'd0);

`ifdef UMI_ARBITER_ONEHOT_CHECK_EN
    @(posedge clk);
    #1;
    force dutRr.r_hold = 4'b0110;
    @(posedge clk);
    #1;
    checkOutput("rr.errOh.forced", 32'(rrErrOh), 32'd1);
    release dutRr.r_hold;
    @(posedge clk);
    #1;
    checkOutput("rr.errOh.sticky", 32'(rrErrOh), 32'd1);
`else
    @(posedge clk);
    #1;
    checkOutput("rr.errOh.disabled", 32'(rrErrOh), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_umi_arbiter
